// File: rtl/seg7_pkg.sv
// Shared segment patterns, handshake state type and width helper for the scan driver.
package seg7_pkg;

    // Segment patterns, bit0 = a ... bit6 = g, logical (active-high) polarity
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Input handshake: idle (ready) or holding a pending word until the frame boundary
    typedef enum logic {
        ST_PEND = 1'b0,
        ST_IDLE = 1'b1
    } hs_state_t;

    // Ceiling log2, never below 1 so a register of that width always exists
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) width++;
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to 7-segment decoder with hex enable and forced blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    input  logic       blank,
    output logic [6:0] seg
);

    // Codes 10..15 only light up in hex mode; blank overrides everything
    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = hex_en ? SEG_A : SEG_BLANK;
                4'hB: seg = hex_en ? SEG_B : SEG_BLANK;
                4'hC: seg = hex_en ? SEG_C : SEG_BLANK;
                4'hD: seg = hex_en ? SEG_D : SEG_BLANK;
                4'hE: seg = hex_en ? SEG_E : SEG_BLANK;
                4'hF: seg = hex_en ? SEG_F : SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver; new words take effect only at frame boundaries.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned ACTIVE_LOW_SEG = 0,
    parameter int unsigned LZ_BLANK       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic [N_DIGITS-1:0]   i_dp,
    input  logic                  i_hex_en,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [N_DIGITS-1:0]   o_an,
    output logic                  o_frame
);

    localparam int unsigned VAL_W = 4 * N_DIGITS;
    localparam int unsigned IDX_W = clog2(N_DIGITS);
    localparam int unsigned CNT_W = clog2(SCAN_DIV);
    localparam logic             INV      = (ACTIVE_LOW_SEG != 0);
    localparam logic             LZ_EN    = (LZ_BLANK != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SCAN_DIV - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    hs_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  frame_q;
    logic [VAL_W-1:0]      pend_value, disp_value;
    logic [N_DIGITS-1:0]   pend_dp, disp_dp;
    logic                  pend_hex, disp_hex;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [N_DIGITS-1:0]   an_q;

    logic                  wrap, wrap_last;
    logic                  load_pend, load_disp_in, load_disp_pend;
    logic [3:0]            digit;
    logic                  digit_dp, blank, all_zero;
    logic [N_DIGITS-1:0]   lz;
    logic [6:0]            dec_seg;

    assign wrap      = (cnt_q == CNT_LAST);
    assign wrap_last = wrap && (idx_q == IDX_LAST);

    // Prescaler, digit index and a frame pulse registered to coincide with the last wrap
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            if (wrap) begin
                cnt_q <= '0;
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            frame_q <= (cnt_q == CNT_PRE) && (idx_q == IDX_LAST);
        end
    end

    // Handshake state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Handshake next state: accept into pending, or straight to display on a boundary
    always_comb begin
        state_d        = state_q;
        load_pend      = 1'b0;
        load_disp_in   = 1'b0;
        load_disp_pend = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (wrap_last) begin
                        load_disp_in = 1'b1;
                    end else begin
                        load_pend = 1'b1;
                        state_d   = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (wrap_last) begin
                    load_disp_pend = 1'b1;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending and display word registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_hex   <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_hex   <= 1'b0;
        end else begin
            if (load_pend) begin
                pend_value <= i_value;
                pend_dp    <= i_dp;
                pend_hex   <= i_hex_en;
            end
            if (load_disp_in) begin
                disp_value <= i_value;
                disp_dp    <= i_dp;
                disp_hex   <= i_hex_en;
            end else if (load_disp_pend) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                disp_hex   <= pend_hex;
            end
        end
    end

    // Leading-zero mask from the top digit down, then mux out the active digit
    always_comb begin
        digit    = 4'h0;
        digit_dp = 1'b0;
        blank    = 1'b0;
        all_zero = 1'b1;
        lz       = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero && (disp_value[4*k +: 4] == 4'h0);
            lz[k]    = all_zero;
        end
        lz[0] = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                digit    = disp_value[4*k +: 4];
                digit_dp = disp_dp[k];
                blank    = LZ_EN && lz[k];
            end
        end
    end

    seg7_decode u_decode (
        .code   (digit),
        .hex_en (disp_hex),
        .blank  (blank),
        .seg    (dec_seg)
    );

    // Output register, polarity applied here so reset values are inverted too
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            seg_q <= {7{INV}};
            dp_q  <= INV;
            an_q  <= {N_DIGITS{INV}};
        end else begin
            seg_q <= dec_seg ^ {7{INV}};
            dp_q  <= digit_dp ^ INV;
            an_q  <= (N_DIGITS'(1) << idx_q) ^ {N_DIGITS{INV}};
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_seg   = seg_q;
    assign o_dp    = dp_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, 4 clocks per slot).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic        ready;
    logic [15:0] value;
    logic [3:0]  dp;
    logic        hex_en;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic        frame;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        hex;
        logic [27:0] segs;   // {k3, k2, k1, k0}
    } vec_t;

    slot_t sb[$];
    vec_t  vecs[9];

    seg7_scan_driver #(
        .N_DIGITS       (4),
        .SCAN_DIV       (4),
        .ACTIVE_LOW_SEG (0),
        .LZ_BLANK       (1)
    ) dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_valid  (valid),
        .o_ready  (ready),
        .i_value  (value),
        .i_dp     (dp),
        .i_hex_en (hex_en),
        .o_seg    (seg),
        .o_dp     (seg_dp),
        .o_an     (an),
        .o_frame  (frame)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [27:0] segs, input logic [3:0] dpv);
        slot_t s;
        for (int k = 0; k < 4; k++) begin
            s.an  = 4'b0001 << k;
            s.seg = segs[7*k +: 7];
            s.dp  = dpv[k];
            sb.push_back(s);
        end
    endtask

    // Returns at the falling edge inside the next o_frame cycle
    task automatic wait_frame();
        int n;
        n = 0;
        @(negedge clk);
        while (!frame && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("frame_seen", 32'(frame), 32'd1);
    endtask

    // Called at the o_frame negedge; checks the start of each slot of the following frame
    task automatic check_slots(input string tag);
        slot_t e;
        @(posedge clk);
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) @(posedge clk);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk($sformatf("%s_sb_empty%0d", tag, k), 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s_an%0d", tag, k), 32'(an), 32'(e.an));
                chk($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(e.seg));
                chk($sformatf("%s_dp%0d", tag, k), 32'(seg_dp), 32'(e.dp));
            end
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d, input logic h);
        int   n;
        logic fr;
        n = 0;
        @(negedge clk);
        while (!ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
        value  = v;
        dp     = d;
        hex_en = h;
        valid  = 1'b1;
        fr     = frame;
        @(negedge clk);
        valid = 1'b0;
        chk("ready_after_xfer", 32'(ready), fr ? 32'd1 : 32'd0);
    endtask

    initial begin
        int n;
        int early;

        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110}};
        vecs[1] = '{16'h00AF, 4'b0000, 1'b1, {7'b0000000, 7'b0000000, 7'b1110111, 7'b1110001}};
        vecs[2] = '{16'h00AF, 4'b0000, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}};
        vecs[3] = '{16'h0000, 4'b0100, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}};
        vecs[4] = '{16'h0102, 4'b1001, 1'b0, {7'b0000000, 7'b0000110, 7'b0111111, 7'b1011011}};
        vecs[5] = '{16'h5678, 4'b1010, 1'b0, {7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111}};
        vecs[6] = '{16'h9CDE, 4'b0001, 1'b1, {7'b1101111, 7'b0111001, 7'b1011110, 7'b1111001}};
        vecs[7] = '{16'hB000, 4'b0000, 1'b1, {7'b1111100, 7'b0111111, 7'b0111111, 7'b0111111}};
        vecs[8] = '{16'hB000, 4'b0000, 1'b0, {7'b0000000, 7'b0111111, 7'b0111111, 7'b0111111}};

        rstn   = 1'b0;
        valid  = 1'b0;
        value  = '0;
        dp     = '0;
        hex_en = 1'b0;

        // Reset values while held
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'd0);
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_dp", 32'(seg_dp), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_frame", 32'(frame), 32'd0);

        // First slot one clock after release, frame timing
        rstn = 1'b1;
        @(negedge clk);
        chk("first_an", 32'(an), 32'd1);
        chk("first_seg", 32'(seg), 32'h3F);
        n = 1;
        while (!frame && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("first_frame_at", 32'(n), 32'd15);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 40);
        chk("frame_period", 32'(n), 32'd16);
        @(negedge clk);
        chk("frame_width", 32'(frame), 32'd0);

        // Table of words
        for (int i = 0; i < 9; i++) begin
            load(vecs[i].value, vecs[i].dp, vecs[i].hex);
            push_word(vecs[i].segs, vecs[i].dp);
            wait_frame();
            check_slots($sformatf("vec%0d", i));
        end

        // Mid-frame load followed by a held second word
        wait_frame();
        repeat (3) @(negedge clk);
        chk("w1_ready", 32'(ready), 32'd1);
        value  = 16'h4321;
        dp     = 4'b0001;
        hex_en = 1'b0;
        valid  = 1'b1;
        @(negedge clk);
        value  = 16'h0F0E;
        dp     = 4'b0010;
        hex_en = 1'b1;
        early  = 0;
        n      = 0;
        while (!frame && n < 64) begin
            if (ready) early++;
            @(negedge clk);
            n++;
        end
        chk("w2_no_early_ready", 32'(early), 32'd0);
        chk("w1_boundary_frame", 32'(frame), 32'd1);
        chk("w1_boundary_ready", 32'(ready), 32'd0);
        push_word({7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110}, 4'b0001);
        push_word({7'b0000000, 7'b1110001, 7'b0111111, 7'b1111001}, 4'b0010);
        fork
            check_slots("w1");
            begin
                @(negedge clk);
                chk("w2_ready_return", 32'(ready), 32'd1);
                @(negedge clk);
                valid = 1'b0;
                chk("w2_accepted", 32'(ready), 32'd0);
            end
        join
        wait_frame();
        check_slots("w2");

        // Reset mid-slot with a word pending
        wait_frame();
        repeat (2) @(negedge clk);
        value  = 16'h8888;
        dp     = 4'b1111;
        hex_en = 1'b0;
        valid  = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("w3_pending", 32'(ready), 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_an", 32'(an), 32'd0);
        chk("mid_rst_seg", 32'(seg), 32'd0);
        chk("mid_rst_dp", 32'(seg_dp), 32'd0);
        chk("mid_rst_ready", 32'(ready), 32'd1);
        chk("mid_rst_frame", 32'(frame), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_an", 32'(an), 32'd1);
        chk("post_rst_seg", 32'(seg), 32'h3F);
        chk("post_rst_dp", 32'(seg_dp), 32'd0);
        push_word({7'b0000000, 7'b0000000, 7'b0000000, 7'b0111111}, 4'b0000);
        wait_frame();
        check_slots("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
